// File: rtl/i2c_reg_slave.sv
// I2C register-write slave: 7-bit device address, 16-bit register address, burst writes.
// Define I2C_SLAVE_READ_EN to add a 2^REG_AW x 8 register file and a read path.
module i2c_reg_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h3C,
    parameter int         REG_AW   = 6
) (
    input  logic        clk_25M,
    input  logic        rst,
    input  logic        i2c_sclk,
    inout  wire         i2c_sdat,
    output logic        wr_pulse,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, AH, AH_ACK, AL, AL_ACK, WD, WD_ACK, RD, RD_MACK
    } state_t;

    state_t      state;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl_q, sda_q;
    logic        sda_oe;
    logic [3:0]  bit_cnt;
    logic [6:0]  shift;
    logic [15:0] reg_addr;

    logic scl, sda, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;

    assign scl       = scl_sync[1];
    assign sda       = sda_sync[1];
    assign scl_rise  = scl & ~scl_q;
    assign scl_fall  = ~scl & scl_q;
    assign start_det = scl & scl_q & sda_q & ~sda;
    assign stop_det  = scl & scl_q & ~sda_q & sda;
    assign rx_byte   = {shift, sda};

    // Open-drain: only ever pull low or float.
    assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk_25M) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], i2c_sclk};
            sda_sync <= {sda_sync[0], i2c_sdat};
            scl_q    <= scl;
            sda_q    <= sda;
        end
    end

`ifdef I2C_SLAVE_READ_EN
    logic       rw;
    logic       mack_ok;
    logic [6:0] tx_shift;
    logic [7:0] rd_byte;
    logic [7:0] regfile [2**REG_AW];

    // NOTE: the register file is deliberately not reset; rst must leave stored bytes intact.
    always_ff @(posedge clk_25M) begin
        if (wr_pulse)
            regfile[wr_addr[REG_AW-1:0]] <= wr_data;
    end

    assign rd_byte = regfile[reg_addr[REG_AW-1:0]];
`endif

    always_ff @(posedge clk_25M) begin
        // NOTE: strobe defaults low every cycle so any set below lasts exactly one clock.
        wr_pulse <= 1'b0;
        if (rst) begin
            state    <= IDLE;
            sda_oe   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            reg_addr <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
`ifdef I2C_SLAVE_READ_EN
            rw       <= 1'b0;
            mack_ok  <= 1'b0;
            tx_shift <= '0;
`endif
        end else if (stop_det) begin
            state   <= IDLE;
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
            busy    <= 1'b0;
        end else if (start_det) begin
            state   <= DEV;
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                IDLE: ;
                DEV, AH, AL, WD: begin
                    if (scl_rise) begin
                        shift   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            case (state)
                                DEV: begin
`ifdef I2C_SLAVE_READ_EN
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        rw    <= rx_byte[0];
                                        state <= DEV_ACK;
                                    end else begin
`else
                                    if (rx_byte == {DEV_ADDR, 1'b0}) begin
                                        state <= DEV_ACK;
                                    end else begin
`endif
                                        state <= IDLE;
                                        busy  <= 1'b0;
                                    end
                                end
                                AH: begin
                                    reg_addr[15:8] <= rx_byte;
                                    state          <= AH_ACK;
                                end
                                AL: begin
                                    reg_addr[7:0] <= rx_byte;
                                    state         <= AL_ACK;
                                end
                                default: begin
                                    wr_pulse <= 1'b1;
                                    wr_addr  <= reg_addr;
                                    wr_data  <= rx_byte;
                                    reg_addr <= reg_addr + 16'd1;
                                    state    <= WD_ACK;
                                end
                            endcase
                        end
                    end
                end
                DEV_ACK, AH_ACK, AL_ACK, WD_ACK: begin
                    // First SCL fall starts the ACK pulse, second fall ends it.
                    if (scl_fall) begin
                        sda_oe <= ~sda_oe;
                        if (sda_oe) begin
                            case (state)
                                DEV_ACK: state <= AH;
                                AH_ACK:  state <= AL;
                                default: state <= WD;
                            endcase
`ifdef I2C_SLAVE_READ_EN
                            if (state == DEV_ACK && rw) begin
                                state    <= RD;
                                tx_shift <= rd_byte[6:0];
                                sda_oe   <= ~rd_byte[7];
                            end
`endif
                        end
                    end
                end
`ifdef I2C_SLAVE_READ_EN
                RD: begin
                    if (scl_rise) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            mack_ok <= 1'b0;
                            state   <= RD_MACK;
                        end else begin
                            tx_shift <= {tx_shift[5:0], 1'b0};
                            sda_oe   <= ~tx_shift[6];
                        end
                    end
                end
                RD_MACK: begin
                    if (scl_rise) begin
                        if (sda) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            mack_ok  <= 1'b1;
                            reg_addr <= reg_addr + 16'd1;
                        end
                    end else if (scl_fall && mack_ok) begin
                        mack_ok  <= 1'b0;
                        tx_shift <= rd_byte[6:0];
                        sda_oe   <= ~rd_byte[7];
                        state    <= RD;
                    end
                end
`endif
                default: begin
                    state  <= IDLE;
                    sda_oe <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
